weight_fetch: RTL and testbench
===============================

# weight_fetch

Sequencer that reads a contiguous run of signed 8-bit weights from the weights ROM and streams them to the neuron MAC datapath over a valid/ready interface. It drives the ROM address, absorbs the ROM's one-cycle read latency (the ROM samples `addr` on the falling edge of `clk`), and buffers weights in a small FIFO so MAC back-pressure never loses data. It sits between `weights_rom` and the MAC.

## Interface
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request pulse; accepted only in IDLE.
- `base_addr`  in  8  first ROM address of the run, sampled with `start`.
- `count`  in  8  number of weights to fetch (0–255), sampled with `start`.
- `busy`  out  1  high from start acceptance until `done`.
- `done`  out  1  one-cycle pulse when the run is complete.
- `rom_addr`  out  8  to ROM `addr`; registered.
- `rom_data`  in  8 signed  from ROM `rom_out`.
- `w_valid`  out  1  FIFO head valid.
- `w_ready`  in  1  MAC accepts head.
- `w_data`  out  8 signed  FIFO head weight.
- `w_last`  out  1  head is the final weight of the run; qualified by `w_valid`.
- `stall_cnt`  out  16  present only with `WEIGHT_FETCH_STATS_EN`.

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: on `start`, latch `base_addr`/`count`. If `count`==0 → `done` next cycle, stay IDLE. Else → FETCH, `busy`=1.
- FETCH: issue one address per cycle when `occupancy + inflight < DEPTH` (occupancy = FIFO entries, inflight = 1 if an issue happened last cycle). Issue: `rom_addr` ← next address, `inflight` ← 1, remaining ← remaining−1. Address increments mod 256 (255 → 0 wraps silently). Last issue → DRAIN.
- Capture: on every edge where `inflight`=1, push `rom_data` into FIFO with tag `last` = (this was the final issue).
- DRAIN: no issues; when the `last`-tagged entry is popped (`w_valid && w_ready && w_last`) → `done` pulse on next cycle, `busy`=0, → IDLE.
- Pop: `w_valid && w_ready`. Push and pop in the same cycle leave occupancy unchanged; FIFO never overflows by construction of the issue rule.
- `start` while `busy` is ignored.
- `rom_addr` holds its last value in IDLE.

## Timing
- Reset values: `rom_addr`=0, `busy`=0, `done`=0, `w_valid`=0, `w_data`=0, `w_last`=0, `stall_cnt`=0; FIFO empty, state IDLE, inflight=0.
- `start` sampled at edge E0 → `rom_addr`=base after E0; ROM reads at following falling edge; FIFO write at E1; `w_valid`=1 after E1 (first weight 1 cycle after acceptance).
- With `w_ready` held high: one weight per cycle, no bubbles; run of N takes N+1 cycles from acceptance to final handshake; `done` high the cycle after the final handshake.
- `w_ready` low: issue stops once FIFO+inflight reaches DEPTH; resumes the cycle after a pop frees space. `w_data`/`w_last` stable while `w_valid && !w_ready`.
- `rst` mid-run: all state cleared immediately, no `done` pulse, partial run discarded.

## Configuration
- `WEIGHT_FETCH_STATS_EN` defined: `stall_cnt` port exists; increments each cycle `w_valid && !w_ready`; saturates at 0xFFFF; cleared on reset and on start acceptance.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset then `start`, base=0x00, count=4, `w_ready`=1 → `w_data` = 0x3E, 0x36, 0xF6, 0x41 on consecutive cycles, `w_last` with 0x41, `done` one cycle later.
- base=0xFE, count=3 → `rom_addr` sequence 0xFE, 0xFF, 0x00; three weights delivered, last = ROM[0x00] = 0x3E.
- base=0x10, count=10, `w_ready` low for 8 cycles after first `w_valid` → no issues beyond DEPTH outstanding, no data lost, all 10 weights in order after release; with macro, `stall_cnt`=8.
- count=0 → `done` pulse 1 cycle after `start`, `w_valid` never asserted, `busy` stays 0.
- `start` pulsed again mid-run → ignored; `rst` asserted after 2 handshakes of a count=6 run → outputs at reset values immediately, next `start` runs cleanly.

Source files
------------

// File: rtl/weight_fetch.sv
// weight_fetch: streams a contiguous run of signed 8-bit weights from the
// weights ROM to the MAC datapath over a valid/ready handshake.
//
// The ROM samples rom_addr on the falling edge of clk. Its data is therefore
// ready at the next rising edge. Every issued address is captured one edge
// later into a DEPTH-entry FIFO. Addresses are issued only while
// FIFO occupancy + in-flight reads stays below DEPTH, so back-pressure can
// never overflow the FIFO.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 run request, accepted only while idle
//   base_addr, count      first ROM address and run length, sampled with start
//   busy, done            run in progress / one-cycle completion pulse
//   rom_addr, rom_data    registered ROM address out, ROM read data in
//   w_valid, w_ready      weight stream handshake
//   w_data, w_last        FIFO head weight and final-of-run tag
//   stall_cnt             cycles with w_valid && !w_ready. It saturates.
//                         The port exists only when WEIGHT_FETCH_STATS_EN
//                         is defined.
//
// Optional feature macro: WEIGHT_FETCH_STATS_EN
module weight_fetch #(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        base_addr,
    input  logic [7:0]        count,
    output logic              busy,
    output logic              done,
    output logic [7:0]        rom_addr,
    input  logic signed [7:0] rom_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic signed [7:0] w_data,
    output logic              w_last
`ifdef WEIGHT_FETCH_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state;
    state_t            state_nx;

    logic [7:0]        next_addr;
    logic [7:0]        remaining;
    logic              inflight;
    logic              inflight_last;

    logic signed [7:0] mem [DEPTH];
    logic [DEPTH-1:0]  tags;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       occ;

    logic              accept;
    logic              issue;
    logic              any_issue;
    logic              last_issue;
    logic              pop;
    logic              final_pop;

    assign accept     = (state == IDLE) && start;
    assign w_valid    = (occ != '0);
    assign pop        = w_valid && w_ready;
    assign w_data     = mem[rd_ptr];
    assign w_last     = w_valid && tags[rd_ptr];
    assign final_pop  = (state == DRAIN) && pop && w_last;

    // The issue at start acceptance is the first of the run. Later issues
    // happen in FETCH and are limited by FIFO occupancy plus the read still
    // in flight.
    assign issue      = (state == FETCH) &&
                        ((occ + {{AW{1'b0}}, inflight}) < (AW+1)'(DEPTH));
    assign any_issue  = (accept && (count != '0)) || issue;
    assign last_issue = accept ? (count == 8'd1) : (remaining == 8'd1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start && (count != '0)) begin
                    state_nx = (count == 8'd1) ? DRAIN : FETCH;
                end
            end
            FETCH: begin
                if (issue && (remaining == 8'd1)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (final_pop) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // Address sequencing and completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr      <= '0;
            next_addr     <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= (accept && (count == '0)) || final_pop;
            inflight      <= any_issue;
            inflight_last <= any_issue && last_issue;
            if (accept && (count != '0)) begin
                rom_addr  <= base_addr;
                next_addr <= base_addr + 8'd1;
                remaining <= count - 8'd1;
            end else if (issue) begin
                rom_addr  <= next_addr;
                next_addr <= next_addr + 8'd1;
                remaining <= remaining - 8'd1;
            end
        end
    end

    // Weight FIFO. The push side is the ROM read issued one edge earlier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            tags   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (inflight) begin
                mem[wr_ptr]  <= rom_data;
                tags[wr_ptr] <= inflight_last;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({inflight, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef WEIGHT_FETCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if (w_valid && !w_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_weight_fetch.sv
module tb_weight_fetch;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic [7:0] rom_addr;
    logic [7:0] rom_data = '0;
    logic       w_valid;
    logic       w_ready;
    logic [7:0] w_data;
    logic       w_last;
`ifdef WEIGHT_FETCH_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    weight_fetch #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_last    (w_last)
`ifdef WEIGHT_FETCH_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // ROM contents: the first four entries are fixed. The rest are addr ^ 0xA5.
    function automatic logic [7:0] rom_val(input logic [7:0] a);
        case (a)
            8'h00:   return 8'h3E;
            8'h01:   return 8'h36;
            8'h02:   return 8'hF6;
            8'h03:   return 8'h41;
            default: return a ^ 8'hA5;
        endcase
    endfunction

    // ROM model: it samples the address on the falling edge.
    always @(negedge clk) rom_data <= rom_val(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / monitor ----------------
    // A run is a list of expected {last, weight} records, popped one per
    // handshake. The monitor samples 1 time unit before each rising edge.
    logic [8:0] exp_q[$];
    bit         m_busy     = 0;
    bit         exp_done   = 0;
    bit         prev_stall = 0;
    logic [7:0] held_data  = '0;
    logic       held_last  = 0;
    int         hs_total   = 0;
    logic [7:0] last_hs_data = '0;
    int         issued = 0, popped = 0, run_len = 0;
    logic [7:0] prev_addr = '0;
    int         stall_m = 0;

    always @(negedge clk) begin
        bit         was_busy;
        logic [8:0] item;
        #4;
        if (rst) begin
            exp_q.delete();
            m_busy = 0; exp_done = 0; prev_stall = 0;
            issued = 0; popped = 0; run_len = 0; stall_m = 0;
        end else begin
            was_busy = m_busy;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(exp_done));
            if (!m_busy) chk("w_valid_idle", 32'(w_valid), 32'd0);
            if (prev_stall) begin
                chk("hold_valid", 32'(w_valid), 32'd1);
                chk("hold_data", 32'(w_data), 32'(held_data));
                chk("hold_last", 32'(w_last), 32'(held_last));
            end
            if (m_busy) begin
                if (rom_addr != prev_addr) issued++;
                prev_addr = rom_addr;
                chk("outstanding_le_depth", 32'(issued - popped <= int'(DEPTH)), 32'd1);
                chk("issues_le_count", 32'(issued <= run_len), 32'd1);
            end
`ifdef WEIGHT_FETCH_STATS_EN
            chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
`endif
            // Now apply the effect of the coming rising edge.
            exp_done   = 0;
            prev_stall = w_valid && !w_ready;
            held_data  = w_data;
            held_last  = w_last;
            if (w_valid && !w_ready && stall_m < 65535) stall_m++;
            if (w_valid && w_ready) begin
                hs_total++;
                last_hs_data = w_data;
                popped++;
                item = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
                chk("weight", 32'({w_last, w_data}), (exp_q.size() == 0 && item == 9'h1FF) ? 32'hDEAD : 32'(item));
                if (item[8]) begin
                    exp_done = 1;
                    m_busy   = 0;
                end
            end
            if (start && !was_busy) begin
                stall_m = 0;
                if (count == 0) begin
                    exp_done = 1;
                end else begin
                    for (int i = 0; i < int'(count); i++)
                        exp_q.push_back({(i == int'(count) - 1), rom_val(base_addr + 8'(i))});
                    m_busy    = 1;
                    issued    = 1;
                    popped    = 0;
                    prev_addr = base_addr;
                    run_len   = int'(count);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Both helpers are entered and left on a falling edge.
    task automatic wait_done(input string nm);
        bit seen = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            #3;
            seen = done;
            @(negedge clk);
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    // mode 0: w_ready always high; 1: mostly high; 2: coin flip (+ stray starts)
    task automatic run(input logic [7:0] b, input logic [7:0] c, input int mode,
                       output int lat, output int nrx, output logic [7:0] lastd);
        int h0 = hs_total;
        bit timed_out = 1;
        base_addr = b; count = c; start = 1;
        w_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        start = 0;
        lat = 0;
        for (int k = 0; k < 2000; k++) begin
            case (mode)
                0:       w_ready = 1'b1;
                1:       w_ready = ($urandom_range(0, 3) != 0);
                default: w_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode != 0 && busy && !done && $urandom_range(0, 7) == 0) begin
                start = 1; base_addr = 8'($urandom); count = 8'($urandom);
            end else begin
                start = 0;
            end
            #3;
            if (done) begin
                timed_out = 0;
                break;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 0;
        w_ready = 1'b1;
        @(negedge clk);
        chk("run_timeout", 32'(timed_out), 32'd0);
        nrx   = hs_total - h0;
        lastd = last_hs_data;
    endtask

    typedef struct {
        logic [7:0] base;
        logic [7:0] cnt;
        logic [7:0] exp_last;
        int         exp_lat;   // rising edges from acceptance until done is seen
    } vec_t;

    vec_t vecs[6];

    initial begin
        int         lat, nrx, h0, n;
        logic [7:0] lastd;

        vecs[0] = '{base: 8'h00, cnt: 8'd4,  exp_last: 8'h41, exp_lat: 5};
        vecs[1] = '{base: 8'hFE, cnt: 8'd3,  exp_last: 8'h3E, exp_lat: 4};
        vecs[2] = '{base: 8'h00, cnt: 8'd0,  exp_last: 8'h00, exp_lat: 0};
        vecs[3] = '{base: 8'h10, cnt: 8'd1,  exp_last: 8'hB5, exp_lat: 2};
        vecs[4] = '{base: 8'h20, cnt: 8'd2,  exp_last: 8'h84, exp_lat: 3};
        vecs[5] = '{base: 8'hF0, cnt: 8'd20, exp_last: 8'h41, exp_lat: 21};

        rst = 1; start = 0; base_addr = 0; count = 0; w_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_w_valid", 32'(w_valid), 32'd0);
        chk("rst_w_data", 32'(w_data), 32'd0);
        chk("rst_w_last", 32'(w_last), 32'd0);
`ifdef WEIGHT_FETCH_STATS_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // Table-driven runs with w_ready held high
        foreach (vecs[i]) begin
            run(vecs[i].base, vecs[i].cnt, 0, lat, nrx, lastd);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_count", i), 32'(nrx), 32'(vecs[i].cnt));
            if (vecs[i].cnt != 0)
                chk($sformatf("vec%0d_last", i), 32'(lastd), 32'(vecs[i].exp_last));
        end

        // Address wrap sequence
        base_addr = 8'hFE; count = 8'd3; start = 1;
        @(posedge clk); @(negedge clk);
        start = 0;
        chk("wrap_addr0", 32'(rom_addr), 32'hFE);
        @(posedge clk); @(negedge clk);
        chk("wrap_addr1", 32'(rom_addr), 32'hFF);
        @(posedge clk); @(negedge clk);
        chk("wrap_addr2", 32'(rom_addr), 32'h00);
        wait_done("wrap");

        // Back-pressure: hold w_ready low for 8 valid cycles
        h0 = hs_total;
        w_ready = 0; base_addr = 8'h10; count = 8'd10; start = 1;
        @(posedge clk); @(negedge clk);
        start = 0;
        n = 0;
        for (int k = 0; k < 100 && n < 8; k++) begin
            #3;
            if (w_valid) n++;
            @(negedge clk);
        end
        chk("stall_cycles", 32'(n), 32'd8);
        chk("stall_rom_addr", 32'(rom_addr), 32'(8'h10 + 8'(DEPTH - 1)));
        chk("stall_valid", 32'(w_valid), 32'd1);
`ifdef WEIGHT_FETCH_STATS_EN
        chk("stall_cnt_8", 32'(stall_cnt), 32'd8);
`endif
        w_ready = 1;
        wait_done("stall");
        chk("stall_rx", 32'(hs_total - h0), 32'd10);
        chk("stall_last", 32'(last_hs_data), 32'hBC);

        // Stray start mid-run, then reset after two handshakes
        h0 = hs_total;
        base_addr = 8'h00; count = 8'd6; start = 1;
        @(posedge clk); @(negedge clk);
        start = 1; base_addr = 8'h80; count = 8'd2;
        @(posedge clk); @(negedge clk);
        start = 0;
        for (int k = 0; k < 50 && hs_total - h0 < 2; k++) @(negedge clk);
        chk("mid_hs2", 32'(hs_total - h0), 32'd2);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1;
        #1;
        chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_w_valid", 32'(w_valid), 32'd0);
        chk("midrst_w_data", 32'(w_data), 32'd0);
        chk("midrst_w_last", 32'(w_last), 32'd0);
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        run(8'h02, 8'd2, 0, lat, nrx, lastd);
        chk("post_rst_latency", 32'(lat), 32'd3);
        chk("post_rst_count", 32'(nrx), 32'd2);
        chk("post_rst_last", 32'(lastd), 32'h41);

        // Randomized runs, checked by the monitor's model
        for (int r = 0; r < 30; r++) begin
            logic [7:0] b, c;
            int md;
            b  = 8'($urandom);
            c  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(30, 60)) : 8'($urandom_range(0, 12));
            md = int'($urandom_range(0, 2));
            run(b, c, md, lat, nrx, lastd);
            chk($sformatf("rand%0d_count", r), 32'(nrx), 32'(c));
            if (c != 0) chk($sformatf("rand%0d_last", r), 32'(lastd), 32'(rom_val(b + c - 8'd1)));
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
